// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: samples PC on fetch_start, runs a req/ack read to imem, and holds IR/PC_plus4 until decode takes them.
// Optional macro FETCH_TIMEOUT_EN: bounds the REQ wait; on expiry a NOP_WORD is delivered and fetch_err pulses.
module if_fetch_unit #(
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PC,
  input  logic              fetch_start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       IR,
  output logic [ADDR_W-1:0] PC_plus4,
  output logic              instr_valid,
  input  logic              IR_taken,
  output logic              busy,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t            state;
  logic              pc_aligned;
  logic [ADDR_W-1:0] addr_plus4;

  assign pc_aligned = (PC[1:0] == 2'b00);
  // Wraps naturally at 2^ADDR_W, so a fetch from the last word yields 0.
  assign addr_plus4 = imem_addr + ADDR_W'(4);
  assign busy       = (state != IDLE);

`ifdef FETCH_TIMEOUT_EN
  localparam int              CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  // NOTE: every register here is state, so the block uses non-blocking
  // assignments only and the asynchronous reset sets each one explicitly.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      IR          <= NOP_WORD;
      PC_plus4    <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      fetch_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_start) begin
            if (pc_aligned) begin
              imem_addr <= PC;
              imem_req  <= 1'b1;
              state     <= REQ;
`ifdef FETCH_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
            end else begin
              fetch_err <= 1'b1;
            end
          end
        end

        REQ: begin
          if (imem_ack) begin
            IR          <= imem_rdata;
            PC_plus4    <= addr_plus4;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= FULL;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == LIMIT) begin
            // Memory never answered: hand decode a NOP rather than stall forever.
            IR          <= NOP_WORD;
            PC_plus4    <= addr_plus4;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            fetch_err   <= 1'b1;
            state       <= FULL;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        FULL: begin
          if (IR_taken) begin
            instr_valid <= 1'b0;
            if (fetch_start && pc_aligned) begin
              imem_addr <= PC;
              imem_req  <= 1'b1;
              state     <= REQ;
`ifdef FETCH_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
            end else begin
              fetch_err <= fetch_start;
              state     <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: per-scenario tasks plus a capture scoreboard.
// Timeout scenarios run only when FETCH_TIMEOUT_EN is defined.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic        fetch_start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IR;
  logic [31:0] PC_plus4;
  logic        instr_valid;
  logic        IR_taken;
  logic        busy;
  logic        fetch_err;

  if_fetch_unit #(.ADDR_W(32), .NOP_WORD(NOP), .TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .reset(reset), .PC(PC), .fetch_start(fetch_start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .IR(IR), .PC_plus4(PC_plus4),
    .instr_valid(instr_valid), .IR_taken(IR_taken), .busy(busy),
    .fetch_err(fetch_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc4;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic valid_q;
  int   errors = 0;
  int   checks = 0;

  // Scoreboard monitor: every rising instr_valid must match the oldest expected capture.
  always @(negedge CLK) begin
    if (instr_valid === 1'b1 && valid_q !== 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL capture_unexpected: IR=%h PC_plus4=%h with nothing expected", IR, PC_plus4);
      end else begin
        mon_e = sb.pop_front();
        if (IR !== mon_e.ir || PC_plus4 !== mon_e.pc4 || fetch_err !== mon_e.err) begin
          errors++;
          $display("FAIL capture: IR=%h PC_plus4=%h fetch_err=%b expected IR=%h PC_plus4=%h fetch_err=%b",
                   IR, PC_plus4, fetch_err, mon_e.ir, mon_e.pc4, mon_e.err);
        end
      end
    end
    valid_q = instr_valid;
  end

  task automatic quiet();
    fetch_start = 1'b0;
    IR_taken    = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    PC    = '0;
    quiet();
    repeat (2) @(negedge CLK);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    checks++; if (IR !== NOP) begin errors++; $display("FAIL reset_ir: got %h want %h", IR, NOP); end
    checks++; if (PC_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want 0", PC_plus4); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", fetch_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_fetch_basic();
    PC = 32'h0000_0040;
    fetch_start = 1'b1;
    sb.push_back('{ir: 32'h2008_0005, pc4: 32'h0000_0044, err: 1'b0});
    @(negedge CLK);
    fetch_start = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL basic_addr: got %h want 40", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b want 0", instr_valid); end
    imem_ack = 1'b1;
    imem_rdata = 32'h2008_0005;
    @(negedge CLK);
    quiet();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: instr_valid got %b want 1", instr_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop: got %b want 0", imem_req); end
    IR_taken = 1'b1;
    @(negedge CLK);
    quiet();
    checks++; if (instr_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL basic_consume: valid=%b busy=%b want 0 0", instr_valid, busy); end
  endtask

  task automatic test_delayed_ack();
    PC = 32'h0000_0040;
    fetch_start = 1'b1;
    sb.push_back('{ir: 32'h8C09_0004, pc4: 32'h0000_0044, err: 1'b0});
    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL delay_hold[%0d]: req=%b addr=%h valid=%b want 1 40 0", i, imem_req, imem_addr, instr_valid);
      end
      // Stray fetch_start and IR_taken during REQ must be ignored.
      fetch_start = 1'b1;
      PC = 32'h0000_0080;
      IR_taken = 1'b1;
      @(negedge CLK);
    end
    quiet();
    imem_ack = 1'b1;
    imem_rdata = 32'h8C09_0004;
    @(negedge CLK);
    quiet();
    checks++; if (instr_valid !== 1'b1 || imem_addr !== 32'h40)
      begin errors++; $display("FAIL delay_capture: valid=%b addr=%h want 1 40", instr_valid, imem_addr); end
  endtask

  task automatic test_back_to_back();
    fetch_start = 1'b1;
    PC = 32'h0000_0044;
    @(negedge CLK);
    quiet();
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL full_ignore: req=%b valid=%b busy=%b want 0 1 1", imem_req, instr_valid, busy); end
    @(negedge CLK);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_not_queued: req got %b want 0", imem_req); end
    IR_taken = 1'b1;
    fetch_start = 1'b1;
    PC = 32'h0000_0044;
    sb.push_back('{ir: 32'h0000_0013, pc4: 32'h0000_0048, err: 1'b0});
    @(negedge CLK);
    quiet();
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h44)
      begin errors++; $display("FAIL b2b_start: valid=%b req=%b addr=%h want 0 1 44", instr_valid, imem_req, imem_addr); end
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_0013;
    @(negedge CLK);
    quiet();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL b2b_capture: valid got %b want 1", instr_valid); end
    IR_taken = 1'b1;
    fetch_start = 1'b1;
    PC = 32'h0000_004A;
    @(negedge CLK);
    quiet();
    checks++; if (instr_valid !== 1'b0 || fetch_err !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0)
      begin errors++; $display("FAIL b2b_misaligned: valid=%b err=%b busy=%b req=%b want 0 1 0 0",
                               instr_valid, fetch_err, busy, imem_req); end
    @(negedge CLK);
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL b2b_err_pulse: got %b want 0", fetch_err); end
  endtask

  task automatic test_misaligned();
    PC = 32'h0000_0042;
    fetch_start = 1'b1;
    @(negedge CLK);
    quiet();
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b want 1", fetch_err); end
    checks++; if (imem_req !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL mis_noreq: req=%b busy=%b want 0 0", imem_req, busy); end
    checks++; if (IR !== 32'h0000_0013 || instr_valid !== 1'b0)
      begin errors++; $display("FAIL mis_ir_hold: IR=%h valid=%b want 00000013 0", IR, instr_valid); end
    // An ack while idle must not produce an instruction.
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    @(negedge CLK);
    quiet();
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL mis_err_pulse: got %b want 0", fetch_err); end
    checks++; if (instr_valid !== 1'b0 || IR !== 32'h0000_0013)
      begin errors++; $display("FAIL idle_ack_ignored: valid=%b IR=%h want 0 00000013", instr_valid, IR); end
  endtask

  task automatic test_wrap();
    PC = 32'hFFFF_FFFC;
    fetch_start = 1'b1;
    sb.push_back('{ir: 32'h1234_5678, pc4: 32'h0000_0000, err: 1'b0});
    @(negedge CLK);
    quiet();
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge CLK);
    quiet();
    checks++; if (PC_plus4 !== 32'h0 || instr_valid !== 1'b1)
      begin errors++; $display("FAIL wrap_pc4: PC_plus4=%h valid=%b want 0 1", PC_plus4, instr_valid); end
    IR_taken = 1'b1;
    @(negedge CLK);
    quiet();
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout_ack_wins();
    PC = 32'h0000_0300;
    fetch_start = 1'b1;
    @(negedge CLK);
    quiet();
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0)
        begin errors++; $display("FAIL tmo_ack_wait[%0d]: req=%b valid=%b want 1 0", i, imem_req, instr_valid); end
      @(negedge CLK);
    end
    imem_ack = 1'b1;
    imem_rdata = 32'hABCD_0001;
    sb.push_back('{ir: 32'hABCD_0001, pc4: 32'h0000_0304, err: 1'b0});
    @(negedge CLK);
    quiet();
    checks++; if (instr_valid !== 1'b1 || fetch_err !== 1'b0)
      begin errors++; $display("FAIL tmo_ack_wins: valid=%b err=%b want 1 0", instr_valid, fetch_err); end
    IR_taken = 1'b1;
    @(negedge CLK);
    quiet();
  endtask

  task automatic test_timeout();
    PC = 32'h0000_0200;
    fetch_start = 1'b1;
    sb.push_back('{ir: NOP, pc4: 32'h0000_0204, err: 1'b1});
    @(negedge CLK);
    quiet();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0)
        begin errors++; $display("FAIL tmo_wait[%0d]: req=%b valid=%b want 1 0", i, imem_req, instr_valid); end
      @(negedge CLK);
    end
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b1 || fetch_err !== 1'b1 || IR !== NOP)
      begin errors++; $display("FAIL tmo_expire: req=%b valid=%b err=%b IR=%h want 0 1 1 %h",
                               imem_req, instr_valid, fetch_err, IR, NOP); end
    @(negedge CLK);
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL tmo_err_pulse: got %b want 0", fetch_err); end
    IR_taken = 1'b1;
    @(negedge CLK);
    quiet();
  endtask
`endif

  task automatic test_reset_mid_req();
    PC = 32'h0000_0100;
    fetch_start = 1'b1;
    @(negedge CLK);
    quiet();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: req got %b want 1", imem_req); end
    #2 reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL rst_mid_async: req=%b busy=%b want 0 0", imem_req, busy); end
    checks++; if (IR !== NOP || instr_valid !== 1'b0)
      begin errors++; $display("FAIL rst_mid_ir: IR=%h valid=%b want %h 0", IR, instr_valid, NOP); end
    #1 reset = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge CLK);
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0)
      begin errors++; $display("FAIL rst_mid_late_ack: valid=%b req=%b want 0 0", instr_valid, imem_req); end
    @(negedge CLK);
    quiet();
    checks++; if (instr_valid !== 1'b0 || IR !== NOP)
      begin errors++; $display("FAIL rst_mid_discard: valid=%b IR=%h want 0 %h", instr_valid, IR, NOP); end
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_delayed_ack();
    test_back_to_back();
    test_misaligned();
    test_wrap();
`ifdef FETCH_TIMEOUT_EN
    test_timeout_ack_wins();
    test_timeout();
`endif
    test_reset_mid_req();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected captures never seen, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
